// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand bypass selection, load-use stall/bubble,
// mispredict flush and cache freeze, with saturating stall/flush counters.
module hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_valid,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_write_reg,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        mispredict,
    input  logic        cache_stall,
    output logic [1:0]  bypass_1,
    output logic [1:0]  bypass_2,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        FREEZE   = 2'd3
    } state_t;

    state_t state;
    state_t resume_state;
    state_t eff_state;

    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic       ex_uses_rt, ex_wr, ex_load;
    logic [4:0] mem_dst;
    logic       mem_wr, mem_load;
    logic [4:0] wb_dst;
    logic       wb_wr;
    logic       load_use;

    // A loaded value is not available in MEM yet, so only WB may forward it.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       src_used,
        input logic [4:0] m_dst,
        input logic       m_wr,
        input logic       m_load,
        input logic [4:0] w_dst,
        input logic       w_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src_used && src != 5'd0) begin
            if (m_wr && m_dst == src && !m_load)
                sel = 2'b01;
            else if (w_wr && w_dst == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    assign bypass_1  = fwd_sel(ex_rs, 1'b1, mem_dst, mem_wr, mem_load, wb_dst, wb_wr);
    assign bypass_2  = fwd_sel(ex_rt, ex_uses_rt, mem_dst, mem_wr, mem_load, wb_dst, wb_wr);
    assign fsm_state = state;

    assign load_use = id_valid && ex_load && ex_wr && (ex_dst != 5'd0) &&
                      ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    // While frozen with cache_stall already released, act as the pre-freeze state.
    always_comb begin
        eff_state = (state == FREEZE) ? resume_state : state;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        if (cache_stall) begin
            stall = 1'b1;
        end else if (mispredict && eff_state != FLUSH) begin
            flush = 1'b1;
        end else if (load_use && eff_state != FLUSH) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            resume_state <= RUN;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dst       <= '0;
            ex_uses_rt   <= 1'b0;
            ex_wr        <= 1'b0;
            ex_load      <= 1'b0;
            mem_dst      <= '0;
            mem_wr       <= 1'b0;
            mem_load     <= 1'b0;
            wb_dst       <= '0;
            wb_wr        <= 1'b0;
        end else if (cache_stall) begin
            if (state != FREEZE)
                resume_state <= state;
            state <= FREEZE;
        end else if (flush) begin
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dst     <= '0;
            ex_uses_rt <= 1'b0;
            ex_wr      <= 1'b0;
            ex_load    <= 1'b0;
            mem_dst    <= '0;
            mem_wr     <= 1'b0;
            mem_load   <= 1'b0;
            wb_dst     <= mem_dst;
            wb_wr      <= mem_wr;
            state      <= FLUSH;
        end else begin
            if (id_valid && !bubble) begin
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_dst     <= id_write_reg;
                ex_uses_rt <= id_uses_rt;
                ex_wr      <= id_reg_write;
                ex_load    <= id_is_load;
            end else begin
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_dst     <= '0;
                ex_uses_rt <= 1'b0;
                ex_wr      <= 1'b0;
                ex_load    <= 1'b0;
            end
            mem_dst  <= ex_dst;
            mem_wr   <= ex_wr;
            mem_load <= ex_load;
            wb_dst   <= mem_dst;
            wb_wr    <= mem_wr;
            state    <= bubble ? LU_STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations plus
// a per-cycle comparison against a pipeline-occupancy model.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_write_reg;
    logic        id_valid, id_uses_rt, id_reg_write, id_is_load;
    logic        mispredict, cache_stall;
    logic [1:0]  bypass_1, bypass_2;
    logic        stall, bubble, flush;
    logic [15:0] stall_cycles, flush_count;
    logic [1:0]  fsm_state;

    hazard_controller dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid), .id_uses_rt(id_uses_rt),
        .id_write_reg(id_write_reg), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .mispredict(mispredict), .cache_stall(cache_stall),
        .bypass_1(bypass_1), .bypass_2(bypass_2), .stall(stall), .bubble(bubble),
        .flush(flush), .stall_cycles(stall_cycles), .flush_count(flush_count),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: in-flight instructions by age (0 = EX, 1 = MEM, 2 = WB).
    typedef struct packed {
        logic [4:0] rs, rt, dst;
        logic       uses_rt, wr, load;
    } ins_t;

    ins_t        pipe[3], n_pipe[3];
    bit          suppress = 1'b0, n_suppress;
    int unsigned m_sc = 0, m_fc = 0, n_sc, n_fc;

    initial for (int i = 0; i < 3; i++) pipe[i] = '0;

    function automatic logic [1:0] model_fwd(input logic [4:0] r, input logic used);
        if (!used || r == 5'd0) return 2'b00;
        if (pipe[1].wr && pipe[1].dst == r && !pipe[1].load) return 2'b01;
        if (pipe[2].wr && pipe[2].dst == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [15:0] sat(input int unsigned v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    always @(negedge clk) begin
        bit   hz, do_mis, do_lu;
        ins_t dec;
        hz = id_valid && pipe[0].load && pipe[0].wr && pipe[0].dst != 5'd0 &&
             (pipe[0].dst == id_rs || (id_uses_rt && pipe[0].dst == id_rt));
        do_mis = !cache_stall && mispredict && !suppress;
        do_lu  = !cache_stall && !do_mis && !suppress && hz;
        if (chk_en) begin
            chk("bypass_1", bypass_1, model_fwd(pipe[0].rs, 1'b1));
            chk("bypass_2", bypass_2, model_fwd(pipe[0].rt, pipe[0].uses_rt));
            chk("stall", stall, cache_stall || do_lu);
            chk("bubble", bubble, do_lu);
            chk("flush", flush, do_mis);
            chk("stall_cycles", stall_cycles, sat(m_sc));
            chk("flush_count", flush_count, sat(m_fc));
        end
        n_pipe = pipe; n_suppress = suppress; n_sc = m_sc; n_fc = m_fc;
        if (reset) begin
            for (int i = 0; i < 3; i++) n_pipe[i] = '0;
            n_suppress = 1'b0; n_sc = 0; n_fc = 0;
        end else if (cache_stall) begin
            n_sc = m_sc + 1;
        end else if (do_mis) begin
            n_pipe[2] = pipe[1]; n_pipe[1] = '0; n_pipe[0] = '0;
            n_suppress = 1'b1; n_fc = m_fc + 1;
        end else begin
            dec = '0;
            if (id_valid && !do_lu)
                dec = '{rs: id_rs, rt: id_rt, dst: id_write_reg,
                        uses_rt: id_uses_rt, wr: id_reg_write, load: id_is_load};
            n_pipe[2] = pipe[1]; n_pipe[1] = pipe[0]; n_pipe[0] = dec;
            n_suppress = 1'b0;
            if (do_lu) n_sc = m_sc + 1;
        end
    end

    always @(posedge clk) begin
        pipe = n_pipe; suppress = n_suppress; m_sc = n_sc; m_fc = n_fc;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] dst, input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_write_reg = dst; id_reg_write = wr; id_is_load = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        nop(); mispredict = 1'b0; cache_stall = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mispredict = 1'b0; cache_stall = 1'b0; nop();
        step(); step(); reset = 1'b0; chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_bypass_1", bypass_1, 2'b00);
        chk("rst_bypass_2", bypass_2, 2'b00);
        chk("rst_stall", {stall, bubble, flush}, 3'b000);
        chk("rst_counters", {stall_cycles, flush_count}, 32'h0);

        // ALU producer -> consumer: MEM forward, then WB forward with a gap
        step();
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); step();
        set_id(1, 5'd3, 5'd1, 1, 5'd4, 1, 0); step();
        nop(); @(negedge clk);
        chk("fwd_mem_b1", bypass_1, 2'b01);
        chk("fwd_mem_b2", bypass_2, 2'b00);
        do_reset();
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); step();
        set_id(1, 5'd6, 5'd7, 1, 5'd8, 1, 0); step();
        set_id(1, 5'd3, 5'd3, 1, 5'd4, 1, 0); step();
        nop(); @(negedge clk);
        chk("fwd_wb_b1", bypass_1, 2'b10);
        chk("fwd_wb_b2", bypass_2, 2'b10);

        // Same register in MEM and WB: MEM wins
        do_reset();
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); step();
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); step();
        set_id(1, 5'd9, 5'd3, 1, 5'd4, 1, 0); step();
        nop(); @(negedge clk);
        chk("prio_b2", bypass_2, 2'b01);
        chk("prio_b1", bypass_1, 2'b00);

        // Load-use: one stall/bubble cycle, then WB forward
        do_reset();
        set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 1); step();
        set_id(1, 5'd5, 5'd2, 1, 5'd6, 1, 0); @(negedge clk);
        chk("lu_stall", {stall, bubble}, 2'b11);
        step(); @(negedge clk);
        chk("lu_release", {stall, bubble}, 2'b00);
        chk("lu_stall_cycles", stall_cycles, 16'd1);
        step(); nop(); @(negedge clk);
        chk("lu_fwd_b1", bypass_1, 2'b10);

        // Load to r0 never stalls or forwards
        do_reset();
        set_id(1, 5'd1, 5'd0, 0, 5'd0, 1, 1); step();
        set_id(1, 5'd0, 5'd0, 1, 5'd6, 1, 0); @(negedge clk);
        chk("r0_stall", stall, 1'b0);
        step(); nop(); @(negedge clk);
        chk("r0_bypass", {bypass_1, bypass_2}, 4'b0000);

        // Mispredict beats load-use and clears EX/MEM
        do_reset();
        set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 1); step();
        set_id(1, 5'd5, 5'd2, 1, 5'd6, 1, 0); mispredict = 1'b1; @(negedge clk);
        chk("mis_flush", {flush, stall, bubble}, 3'b100);
        step(); mispredict = 1'b0; @(negedge clk);
        chk("mis_flush_count", flush_count, 16'd1);
        chk("mis_flush_state_stall", {stall, flush}, 2'b00);
        step(); nop(); @(negedge clk);
        chk("mis_cleared_b1", bypass_1, 2'b00);

        // Freeze during LU_STALL, with a mispredict that must be ignored
        do_reset();
        set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 1); step();
        set_id(1, 5'd5, 5'd2, 1, 5'd6, 1, 0); step();
        cache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mispredict = (i == 1);
            @(negedge clk);
            chk("frz_stall", {stall, bubble, flush}, 3'b100);
            chk("frz_bypass", {bypass_1, bypass_2}, 4'b0000);
            step();
        end
        cache_stall = 1'b0; mispredict = 1'b0; @(negedge clk);
        chk("frz_resume", {stall, bubble, flush}, 3'b000);
        chk("frz_stall_cycles", stall_cycles, 16'd4);
        step(); nop(); @(negedge clk);
        chk("frz_fwd_b1", bypass_1, 2'b10);

        // Reset in the middle of a load-use stall wins at the same edge
        do_reset();
        set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 1); step();
        set_id(1, 5'd5, 5'd2, 1, 5'd6, 1, 0); reset = 1'b1; step();
        reset = 1'b0; nop(); @(negedge clk);
        chk("rst_mid_stall", {stall_cycles, 2'b00, fsm_state}, 32'h0);

        // Saturation of stall counter, then cleared by reset
        do_reset();
        cache_stall = 1'b1;
        repeat (70000) step();
        @(negedge clk);
        chk("sat_stall_cycles", stall_cycles, 16'hFFFF);
        cache_stall = 1'b0; reset = 1'b1; step(); reset = 1'b0; @(negedge clk);
        chk("sat_reset", stall_cycles, 16'h0);

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter: none; register index width fixed at 5, counter width fixed at 16.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-004 id_rs, id_rt  in  5 each  source regs of instruction in DECODE.
REQ-005 id_valid  in  1  DECODE holds a real instruction.
REQ-006 id_uses_rt  in  1  DECODE instruction reads rt (R-format/store/branch).
REQ-007 id_write_reg  in  5  destination of DECODE instruction (rd if R-format, else rt).
REQ-008 id_reg_write, id_is_load  in  1 each  DECODE instruction writes a reg / is a load.
REQ-009 mispredict  in  1  branch misprediction resolved in MEMORY this cycle.
REQ-010 cache_stall  in  1  memory system freeze request.
REQ-011 bypass_1, bypass_2  out  2 each  EXECUTE operand select: 00 regfile, 01 MEM, 10 WB; 11 never driven.
REQ-012 stall  out  1  hold PC and FETCH/DECODE registers.
REQ-013 bubble  out  1  load zeros into DECODE/EXECUTE pipeline register.
REQ-014 flush  out  1  clear FETCH, DECODE, EXECUTE pipeline registers.
REQ-015 stall_cycles, flush_count  out  16 each  saturating performance counters.

Function
REQ-016 Block SHALL keep shadow records per stage: EX {rs, rt, uses_rt, dst, wr, load}, MEM {dst, wr, load}, WB {dst, wr}.
REQ-017 Normal advance edge: EX<-DECODE inputs (zero if !id_valid or bubble), MEM<-EX, WB<-MEM.
REQ-018 bypass_1 SHALL be 01 if MEM.wr && MEM.dst==EX.rs && EX.rs!=0 && !MEM.load; else 10 if WB.wr && WB.dst==EX.rs && EX.rs!=0; else 00.
REQ-019 bypass_2 SHALL apply REQ-018 to EX.rt, and be 00 when !EX.uses_rt.
REQ-020 MEM match SHALL take priority over WB match for the same register.
REQ-021 Load-use hazard SHALL be: id_valid && EX.load && EX.wr && EX.dst!=0 && (EX.dst==id_rs || (id_uses_rt && EX.dst==id_rt)).
REQ-022 FSM states RUN, LU_STALL, FLUSH, FREEZE; encoding is implementer's choice.
REQ-023 RUN: load-use -> stall=1, bubble=1 same cycle (combinational), next state LU_STALL.
REQ-024 LU_STALL: lasts exactly one cycle, stall=0, bubble=0, re-evaluates hazard as RUN does; returns to RUN (or LU_STALL on new hazard).
REQ-025 mispredict in RUN/LU_STALL: flush=1 same cycle, stall=0, bubble=0; at the edge EX and MEM shadows cleared, WB<-MEM; next state FLUSH.
REQ-026 FLUSH: one cycle, hazard detection suppressed, stall=0; returns to RUN.
REQ-027 cache_stall: stall=1, bubble=0, flush=0; all shadows and bypass selects hold; state FREEZE; on deassertion returns to the state held before freezing.
REQ-028 Priority SHALL be reset > cache_stall > mispredict > load-use.
REQ-029 mispredict asserted during cache_stall SHALL be ignored; controller acts on it only once cache_stall is low.
REQ-030 stall_cycles SHALL increment on each cycle stall=1; flush_count on each cycle flush=1; both saturate at 16'hFFFF.
REQ-031 Register 0 SHALL never cause forwarding or stalls.

Reset
REQ-032 Reset SHALL clear all shadows, counters, state to RUN; bypass_1=bypass_2=00, stall=bubble=flush=0 the cycle after reset.
REQ-033 Reset asserted mid-stall, mid-flush or during cache_stall SHALL override all, same edge.

Verification
REQ-034 ADD r3 issued, next ADD reads r3 as rs -> bypass_1=01 in consumer's EX cycle; one gap instr -> 10.
REQ-035 LW r5 then ADD rs=r5 -> stall=1,bubble=1 one cycle, stall_cycles=1, then bypass_1=10 in consumer EX.
REQ-036 LW r0 followed by reader of r0 -> no stall, bypass 00.
REQ-037 mispredict=1 while load-use detected -> flush=1, stall=0, flush_count=1, EX/MEM shadows zero next cycle.
REQ-038 cache_stall held 3 cycles during LU_STALL -> stall=1 for 3 cycles, bypass unchanged, resumes LU_STALL behaviour afterwards.
REQ-039 Force 70000 stall cycles -> stall_cycles holds 16'hFFFF; reset -> 0.
